// File: rtl/ll_pkg.sv
// Shared types and constants for the line-length compute chain.
package ll_pkg;

    localparam int unsigned DEF_DATA_WIDTH = 32;
    localparam int unsigned DEF_IN_WIDTH   = DEF_DATA_WIDTH + 1;

    typedef enum logic {
        FILL = 1'b0,
        RUN  = 1'b1
    } ll_state_e;

    // Width of a sum of win_len values that each fit in in_w bits.
    function automatic int unsigned sum_width(input int unsigned in_w, input int unsigned win_len);
        return in_w + $clog2(win_len);
    endfunction

endpackage

// File: rtl/ll_win_buf.sv
// Circular sample buffer; the read port always presents the slot the next write will overwrite.
module ll_win_buf #(
    parameter int unsigned WIDTH = 33,
    parameter int unsigned DEPTH = 256
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr_i,
    input  logic             wr_en_i,
    input  logic [WIDTH-1:0] wr_data_i,
    output logic [WIDTH-1:0] rd_data_o
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    wr_ptr_d;
    logic [WIDTH-1:0] rd_data_q;
    logic             kill;

    assign kill = !rst || clr_i;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        if (kill) begin
            wr_ptr_d = '0;
        end else if (wr_en_i) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
    end

    // Read the slot at the next pointer so the oldest sample is ready for the following accept.
    always_ff @(posedge clk) begin
        wr_ptr_q  <= wr_ptr_d;
        rd_data_q <= mem_q[wr_ptr_d];
    end

    always_ff @(posedge clk) begin
        if (!kill && wr_en_i) begin
            mem_q[wr_ptr_q] <= wr_data_i;
        end
    end

    assign rd_data_o = rd_data_q;

endmodule

// File: rtl/ll_window_detector.sv
// Sliding-window line-length sum with debounced threshold detection.
module ll_window_detector
    import ll_pkg::*;
#(
    parameter  int unsigned IN_WIDTH  = DEF_IN_WIDTH,
    parameter  int unsigned WIN_LEN   = 256,
    parameter  int unsigned HOLD_CNT  = 4,
    localparam int unsigned SUM_WIDTH = sum_width(IN_WIDTH, WIN_LEN)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clr,
    input  logic [IN_WIDTH-1:0]  din,
    input  logic                 din_valid,
    input  logic [SUM_WIDTH-1:0] threshold,
    output logic [SUM_WIDTH-1:0] ll_sum,
    output logic                 sum_valid,
    output logic                 window_full,
    output logic                 detect,
    output logic                 neg_err
);

    localparam int unsigned CNT_W = $clog2(WIN_LEN);
    localparam int unsigned HC_W  = $clog2(HOLD_CNT + 1);

    ll_state_e            state_q, state_d;
    logic [CNT_W-1:0]     fill_cnt_q, fill_cnt_d;
    logic [SUM_WIDTH-1:0] sum_q, sum_d;
    logic                 sum_valid_q, sum_valid_d;
    logic                 full_q, full_d;
    logic                 detect_q, detect_d;
    logic                 neg_err_q, neg_err_d;
    logic [HC_W-1:0]      hi_q, hi_d;
    logic [HC_W-1:0]      lo_q, lo_d;

    logic                 kill;
    logic                 din_neg;
    logic [IN_WIDTH-1:0]  new_val;
    logic [IN_WIDTH-1:0]  old_raw;
    logic [SUM_WIDTH-1:0] new_ext;
    logic [SUM_WIDTH-1:0] old_ext;

    assign kill    = !rst || clr;
    assign din_neg = din[IN_WIDTH-1];
    assign new_val = din_neg ? '0 : din;
    assign new_ext = SUM_WIDTH'(new_val);
    // Until the window is full the slot being replaced holds nothing that belongs to the sum.
    assign old_ext = (state_q == RUN) ? SUM_WIDTH'(old_raw) : '0;

    ll_win_buf #(
        .WIDTH (IN_WIDTH),
        .DEPTH (WIN_LEN)
    ) u_buf (
        .clk       (clk),
        .rst       (rst),
        .clr_i     (clr),
        .wr_en_i   (din_valid),
        .wr_data_i (new_val),
        .rd_data_o (old_raw)
    );

    always_ff @(posedge clk) begin
        state_q     <= state_d;
        fill_cnt_q  <= fill_cnt_d;
        sum_q       <= sum_d;
        sum_valid_q <= sum_valid_d;
        full_q      <= full_d;
        detect_q    <= detect_d;
        neg_err_q   <= neg_err_d;
        hi_q        <= hi_d;
        lo_q        <= lo_d;
    end

    always_comb begin
        state_d     = state_q;
        fill_cnt_d  = fill_cnt_q;
        sum_d       = sum_q;
        sum_valid_d = 1'b0;
        full_d      = full_q;
        detect_d    = detect_q;
        neg_err_d   = neg_err_q;
        hi_d        = hi_q;
        lo_d        = lo_q;

        if (kill) begin
            state_d    = FILL;
            fill_cnt_d = '0;
            sum_d      = '0;
            full_d     = 1'b0;
            detect_d   = 1'b0;
            neg_err_d  = 1'b0;
            hi_d       = '0;
            lo_d       = '0;
        end else if (din_valid) begin
            sum_valid_d = 1'b1;
            sum_d       = sum_q + new_ext - old_ext;
            if (din_neg) begin
                neg_err_d = 1'b1;
            end

            if (state_q == FILL) begin
                fill_cnt_d = fill_cnt_q + CNT_W'(1);
                if (fill_cnt_q == CNT_W'(WIN_LEN - 1)) begin
                    state_d = RUN;
                    full_d  = 1'b1;
                end
            end

            // Run-length debounce, only on results that cover a whole window.
            if (full_d) begin
                if (sum_d > threshold) begin
                    lo_d = '0;
                    if (hi_q != HC_W'(HOLD_CNT)) begin
                        hi_d = hi_q + HC_W'(1);
                    end
                end else begin
                    hi_d = '0;
                    if (lo_q != HC_W'(HOLD_CNT)) begin
                        lo_d = lo_q + HC_W'(1);
                    end
                end
                if (hi_d == HC_W'(HOLD_CNT)) begin
                    detect_d = 1'b1;
                end else if (lo_d == HC_W'(HOLD_CNT)) begin
                    detect_d = 1'b0;
                end
            end
        end
    end

    assign ll_sum      = sum_q;
    assign sum_valid   = sum_valid_q;
    assign window_full = full_q;
    assign detect      = detect_q;
    assign neg_err     = neg_err_q;

endmodule

// File: tb/tb_ll_window_detector.sv
// Scoreboard bench for ll_window_detector with WIN_LEN=8, HOLD_CNT=2.
module tb_ll_window_detector;

    localparam int unsigned IW = 33;
    localparam int unsigned WL = 8;
    localparam int unsigned HC = 2;
    localparam int unsigned SW = IW + 3;

    typedef struct {
        logic [SW-1:0] sum;
        logic          full;
        logic          det;
        logic          neg;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          clr = 1'b0;
    logic [IW-1:0] din = '0;
    logic          din_valid = 1'b0;
    logic [SW-1:0] threshold = '0;
    logic [SW-1:0] ll_sum;
    logic          sum_valid;
    logic          window_full;
    logic          detect;
    logic          neg_err;

    int checks   = 0;
    int failures = 0;
    exp_t sb_q[$];

    logic [IW-1:0] m_buf [WL];
    int            m_ptr, m_cnt, m_hi, m_lo;
    logic [SW-1:0] m_sum;
    logic          m_full, m_det, m_neg;

    always #5 clk = ~clk;

    ll_window_detector #(.IN_WIDTH(IW), .WIN_LEN(WL), .HOLD_CNT(HC)) dut (
        .clk(clk), .rst(rst), .clr(clr), .din(din), .din_valid(din_valid),
        .threshold(threshold), .ll_sum(ll_sum), .sum_valid(sum_valid),
        .window_full(window_full), .detect(detect), .neg_err(neg_err)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_ptr = 0; m_cnt = 0; m_hi = 0; m_lo = 0;
        m_sum = '0; m_full = 1'b0; m_det = 1'b0; m_neg = 1'b0;
    endtask

    task automatic model_accept(input logic [IW-1:0] d, input logic [SW-1:0] thr);
        logic [IW-1:0] cond;
        logic [IW-1:0] old;
        exp_t e;
        cond = d[IW-1] ? '0 : d;
        if (d[IW-1]) m_neg = 1'b1;
        old = m_full ? m_buf[m_ptr] : '0;
        m_sum = m_sum + SW'(cond) - SW'(old);
        m_buf[m_ptr] = cond;
        m_ptr = (m_ptr + 1) % WL;
        if (!m_full) begin
            m_cnt++;
            if (m_cnt == WL) m_full = 1'b1;
        end
        if (m_full) begin
            if (m_sum > thr) begin
                m_lo = 0;
                if (m_hi < HC) m_hi++;
            end else begin
                m_hi = 0;
                if (m_lo < HC) m_lo++;
            end
            if (m_hi == HC) m_det = 1'b1;
            else if (m_lo == HC) m_det = 1'b0;
        end
        e.sum = m_sum; e.full = m_full; e.det = m_det; e.neg = m_neg;
        sb_q.push_back(e);
    endtask

    // Entry/exit point of every driving task: 1 time unit after a rising edge.
    task automatic send(input logic [IW-1:0] d, input logic [SW-1:0] thr);
        din = d; threshold = thr; din_valid = 1'b1;
        model_accept(d, thr);
        @(posedge clk); #1;
        din_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic pulse_clr(input logic with_valid);
        clr = 1'b1; din = IW'(7); din_valid = with_valid;
        model_reset();
        @(posedge clk); #1;
        clr = 1'b0; din_valid = 1'b0;
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_sum"}, 64'(ll_sum), 64'd0);
        check({tag, "_vld"}, 64'(sum_valid), 64'd0);
        check({tag, "_full"}, 64'(window_full), 64'd0);
        check({tag, "_det"}, 64'(detect), 64'd0);
        check({tag, "_neg"}, 64'(neg_err), 64'd0);
    endtask

    // Output monitor: every sum_valid pulse must match the oldest pending expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (sum_valid) begin
                if (sb_q.size() == 0) begin
                    check("unexpected_valid", 64'd1, 64'd0);
                end else begin
                    e = sb_q.pop_front();
                    check("sb_sum", 64'(ll_sum), 64'(e.sum));
                    check("sb_full", 64'(window_full), 64'(e.full));
                    check("sb_det", 64'(detect), 64'(e.det));
                    check("sb_neg", 64'(neg_err), 64'(e.neg));
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        model_reset();
        rst = 1'b0;
        idle(2);
        rst = 1'b1;
        check_zero("reset");

        // Fill with 5s.
        for (int i = 0; i < 8; i++) begin
            send(IW'(5), SW'(100));
            if (i == 6) check("fill7_full", 64'(window_full), 64'd0);
        end
        check("fill_sum", 64'(ll_sum), 64'd40);
        check("fill_full", 64'(window_full), 64'd1);
        check("fill_det", 64'(detect), 64'd0);

        // Slide with 1s, including pointer wrap.
        for (int i = 0; i < 8; i++) send(IW'(1), SW'(100));
        check("slide_sum", 64'(ll_sum), 64'd8);
        idle(2);
        check("idle_vld", 64'(sum_valid), 64'd0);
        check("idle_sum", 64'(ll_sum), 64'd8);

        // Detect assert then release.
        pulse_clr(1'b0);
        check_zero("clr");
        for (int i = 0; i < 8; i++) send(IW'(5), SW'(30));
        check("det_after8", 64'(detect), 64'd0);
        send(IW'(5), SW'(30));
        check("det_after9", 64'(detect), 64'd1);
        send(IW'(0), SW'(39));
        check("det_lo1", 64'(detect), 64'd1);
        send(IW'(0), SW'(39));
        check("det_lo2", 64'(detect), 64'd0);
        check("det_sum", 64'(ll_sum), 64'd30);

        // Equality and alternating 31/30 never assert detect.
        pulse_clr(1'b0);
        for (int i = 0; i < 7; i++) send(IW'(4), SW'(30));
        send(IW'(2), SW'(30));
        check("eq_sum", 64'(ll_sum), 64'd30);
        for (int i = 0; i < 6; i++) begin
            send((i % 2 == 0) ? IW'(5) : IW'(3), SW'(30));
            check("alt_det", 64'(detect), 64'd0);
        end

        // Gaps, then clr together with a valid mid-fill.
        pulse_clr(1'b0);
        for (int i = 0; i < 4; i++) begin send(IW'(5), SW'(30)); idle(2); end
        check("gap_sum", 64'(ll_sum), 64'd20);
        pulse_clr(1'b1);
        check_zero("clr_valid");
        for (int i = 0; i < 8; i++) begin
            send(IW'(5), SW'(30));
            if (i == 6) check("refill7_full", 64'(window_full), 64'd0);
            idle(1);
        end
        check("refill_sum", 64'(ll_sum), 64'd40);
        check("refill_full", 64'(window_full), 64'd1);
        send(IW'(5), SW'(30));
        check("pre_rst_det", 64'(detect), 64'd1);

        // Reset in RUN with a simultaneous valid, then negative sample handling.
        rst = 1'b0; din_valid = 1'b1; din = IW'(9);
        model_reset();
        @(posedge clk); #1;
        rst = 1'b1; din_valid = 1'b0;
        check_zero("rst_run");
        send(33'h1_FFFF_FFFD, SW'(100));
        check("neg_set", 64'(neg_err), 64'd1);
        check("neg_sum", 64'(ll_sum), 64'd0);
        send(IW'(2), SW'(100));
        check("neg_sticky", 64'(neg_err), 64'd1);
        check("neg_sum2", 64'(ll_sum), 64'd2);
        pulse_clr(1'b0);
        check("neg_clr", 64'(neg_err), 64'd0);

        idle(3);
        check("sb_empty", 64'(sb_q.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
